// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch channel: req/addr out, gnt/rvalid/rdata back.
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues credit-limited word fetches, buffers
// in-order responses and presents a registered instruction to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    instruction_fetch_if.master imem,
    output logic [31:0] instruction,
    output logic [31:0] cnt_val_pl4_out,
    output logic [31:0] pc_out,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        pc_q;
    logic [31:0]        pcq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   pcq_wr;
    logic [PTR_W-1:0]   pcq_rd;
    logic [CNT_W-1:0]   outstanding;
    fetch_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   fifo_wr;
    logic [PTR_W-1:0]   fifo_rd;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W-1:0]   kill_cnt;

    logic               rsp;
    logic               issue;
    logic               kill;
    logic               push;
    logic               pop;
    logic               credit;
    logic [SUM_W-1:0]   in_use;
    logic [CNT_W-1:0]   kill_load;
    fetch_entry_t       rsp_entry;
    fetch_entry_t       out_entry;

    // Handshake decode, credit check and output-stage source selection.
    always_comb begin
        in_use    = SUM_W'(outstanding) + SUM_W'(fifo_cnt);
        credit    = in_use < SUM_W'(FIFO_DEPTH);
        rsp       = imem.rvalid && (outstanding != '0);
        kill      = rsp && (kill_cnt != '0);
        push      = rsp && !kill && !redirect;
        pop       = !stall && !redirect && ((fifo_cnt != '0) || push);
        kill_load = outstanding - CNT_W'(rsp);
        rsp_entry = '{pc: pcq_mem[pcq_rd], instr: imem.rdata};
        out_entry = (fifo_cnt != '0) ? fifo_mem[fifo_rd] : rsp_entry;
        issue     = imem.req && imem.gnt;
    end

    assign imem.req  = (state != BOOT) && !redirect && credit;
    assign imem.addr = pc_q;

    // Storage arrays; validity is tracked by the pointers and counts below.
    always_ff @(posedge clk) begin
        if (issue) pcq_mem[pcq_wr] <= pc_q;
        if (push)  fifo_mem[fifo_wr] <= rsp_entry;
    end

    // FSM, PC, credit tracking, fetch buffer and registered decode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= BOOT;
            pc_q            <= RESET_PC;
            pcq_wr          <= '0;
            pcq_rd          <= '0;
            outstanding     <= '0;
            fifo_wr         <= '0;
            fifo_rd         <= '0;
            fifo_cnt        <= '0;
            kill_cnt        <= '0;
            instruction     <= NOP_INSTR;
            cnt_val_pl4_out <= '0;
            pc_out          <= '0;
            if_valid        <= 1'b0;
        end else begin
            if (issue) begin
                pcq_wr <= pcq_wr + PTR_W'(1);
                pc_q   <= pc_q + 32'd4;
            end
            if (rsp) pcq_rd <= pcq_rd + PTR_W'(1);

            case ({issue, rsp})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect) begin
                // Stale responses are counted out via kill_cnt, not via the PC queue.
                pc_q        <= redirect_pc & 32'hFFFF_FFFC;
                fifo_wr     <= '0;
                fifo_rd     <= '0;
                fifo_cnt    <= '0;
                kill_cnt    <= kill_load;
                state       <= (kill_load != '0) ? FLUSH : RUN;
                if_valid    <= 1'b0;
                instruction <= NOP_INSTR;
            end else begin
                if (push) fifo_wr <= fifo_wr + PTR_W'(1);
                if (pop)  fifo_rd <= fifo_rd + PTR_W'(1);
                if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
                else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);

                if (kill) kill_cnt <= kill_cnt - CNT_W'(1);

                case (state)
                    BOOT:    state <= RUN;
                    FLUSH:   if (kill && (kill_cnt == CNT_W'(1))) state <= RUN;
                    default: state <= state;
                endcase

                if (!stall) begin
                    if (pop) begin
                        if_valid        <= 1'b1;
                        instruction     <= out_entry.instr;
                        pc_out          <= out_entry.pc;
                        cnt_val_pl4_out <= out_entry.pc + 32'd4;
                    end else begin
                        if_valid    <= 1'b0;
                        instruction <= NOP_INSTR;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and decode-bubble counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (!stall && !redirect && !pop) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

    // A response with nothing in flight is a memory-side protocol error.
    rsp_legal: assert property (@(posedge clk) disable iff (!rst)
        !(imem.rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns addr+0xA000 one
// cycle after each grant unless responses are held back.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        gnt_en = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] instruction;
    logic [31:0] cnt_val_pl4_out;
    logic [31:0] pc_out;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] rsp_q[$];
    logic [31:0] rsp_addr;
    logic [96:0] out_v;
    logic [32:0] req_v;

    instruction_fetch_if imem_bus();

    assign imem_bus.gnt = gnt_en;
    assign out_v = {if_valid, pc_out, cnt_val_pl4_out, instruction};
    assign req_v = {imem_bus.req, imem_bus.addr};

    instruction_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem_bus),
        .instruction     (instruction),
        .cnt_val_pl4_out (cnt_val_pl4_out),
        .pc_out          (pc_out),
        .if_valid        (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: in-order, one response per cycle, first response the cycle after grant.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q.delete();
            imem_bus.rvalid <= 1'b0;
            imem_bus.rdata  <= '0;
        end else begin
            if (imem_bus.req && imem_bus.gnt) rsp_q.push_back(imem_bus.addr);
            if (!hold && (rsp_q.size() != 0)) begin
                rsp_addr = rsp_q.pop_front();
                imem_bus.rvalid <= 1'b1;
                imem_bus.rdata  <= rsp_addr + 32'h0000_A000;
            end else begin
                imem_bus.rvalid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt_en = 1'b1; hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; gnt_en = 1'b1; hold = 1'b0;
        tick();
        tick();
        checks++;
        if (out_v !== {1'b0, 32'h0, 32'h0, NOP}) begin
            fails++; $display("FAIL reset_out: got %h want %h", out_v, {1'b0, 32'h0, 32'h0, NOP});
        end
        checks++;
        if (req_v !== {1'b0, RST_PC}) begin
            fails++; $display("FAIL reset_req: got %h want %h", req_v, {1'b0, RST_PC});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_bus.req !== 1'b0) begin
            fails++; $display("FAIL boot_noreq: got %b want 0", imem_bus.req);
        end
        tick();
        checks++;
        if (req_v !== {1'b1, RST_PC}) begin
            fails++; $display("FAIL first_req: got %h want %h", req_v, {1'b1, RST_PC});
        end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        do_reset();
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            fails++; $display("FAIL stream_lat: got %b want 0", if_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            p = RST_PC + 32'(4 * i);
            checks++;
            if (out_v !== {1'b1, p, p + 32'd4, p + 32'h0000_A000}) begin
                fails++; $display("FAIL stream_%0d: got %h want %h", i, out_v, {1'b1, p, p + 32'd4, p + 32'h0000_A000});
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({if_valid, pc_out} !== {1'b1, 32'h0000_0108}) begin
                fails++; $display("FAIL stall_hold_%0d: got %h want %h", i, {if_valid, pc_out}, {1'b1, 32'h0000_0108});
            end
            checks++;
            if (imem_bus.req !== 1'b0) begin
                fails++; $display("FAIL stall_noreq_%0d: got %b want 0", i, imem_bus.req);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            p = 32'h0000_010C + 32'(4 * i);
            checks++;
            if (out_v !== {1'b1, p, p + 32'd4, p + 32'h0000_A000}) begin
                fails++; $display("FAIL stall_resume_%0d: got %h want %h", i, out_v, {1'b1, p, p + 32'd4, p + 32'h0000_A000});
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        hold = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (imem_bus.req !== 1'b0) begin
            fails++; $display("FAIL redir_credit: got %b want 0", imem_bus.req);
        end
        redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        tick();
        redirect = 1'b0;
        hold = 1'b0;
        checks++;
        if ({2'(dut.state), 32'(dut.kill_cnt), imem_bus.addr} !== {2'd2, 32'd2, 32'h0000_2000}) begin
            fails++; $display("FAIL redir_flush: got %h want %h", {2'(dut.state), 32'(dut.kill_cnt), imem_bus.addr}, {2'd2, 32'd2, 32'h0000_2000});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_v !== {1'b0, 32'h0, 32'h0, NOP}) begin
                fails++; $display("FAIL redir_gap_%0d: got %h want %h", i, out_v, {1'b0, 32'h0, 32'h0, NOP});
            end
            tick();
        end
        checks++;
        if (out_v !== {1'b1, 32'h0000_2000, 32'h0000_2004, 32'h0000_C000}) begin
            fails++; $display("FAIL redir_target: got %h want %h", out_v, {1'b1, 32'h0000_2000, 32'h0000_2004, 32'h0000_C000});
        end
        checks++;
        if (2'(dut.state) !== 2'd1) begin
            fails++; $display("FAIL redir_run: got %0d want 1", 2'(dut.state));
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        hold = 1'b1;
        tick();
        tick();
        tick();
        hold = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect = 1'b0;
        checks++;
        if ({32'(dut.kill_cnt), if_valid} !== {32'd1, 1'b0}) begin
            fails++; $display("FAIL rv_kill: got %h want %h", {32'(dut.kill_cnt), if_valid}, {32'd1, 1'b0});
        end
        tick();
        checks++;
        if ({32'(dut.kill_cnt), if_valid} !== {32'd0, 1'b0}) begin
            fails++; $display("FAIL rv_drain: got %h want %h", {32'(dut.kill_cnt), if_valid}, {32'd0, 1'b0});
        end
        tick();
        checks++;
        if (out_v !== {1'b1, 32'h0000_3000, 32'h0000_3004, 32'h0000_D000}) begin
            fails++; $display("FAIL rv_target: got %h want %h", out_v, {1'b1, 32'h0000_3000, 32'h0000_3004, 32'h0000_D000});
        end
    endtask

    task automatic test_gnt_low();
        do_reset();
        gnt_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (req_v !== {1'b1, RST_PC}) begin
                fails++; $display("FAIL gnt_req_%0d: got %h want %h", i, req_v, {1'b1, RST_PC});
            end
            checks++;
            if ({if_valid, instruction} !== {1'b0, NOP}) begin
                fails++; $display("FAIL gnt_nop_%0d: got %h want %h", i, {if_valid, instruction}, {1'b0, NOP});
            end
        end
        gnt_en = 1'b1;
        tick();
        tick();
        checks++;
        if (out_v !== {1'b1, RST_PC, RST_PC + 32'd4, RST_PC + 32'h0000_A000}) begin
            fails++; $display("FAIL gnt_first: got %h want %h", out_v, {1'b1, RST_PC, RST_PC + 32'd4, RST_PC + 32'h0000_A000});
        end
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        hold = 1'b1;
        tick();
        tick();
        checks++;
        if ({32'(dut.outstanding), pc_out} !== {32'd2, 32'h0000_0108}) begin
            fails++; $display("FAIL mid_pre: got %h want %h", {32'(dut.outstanding), pc_out}, {32'd2, 32'h0000_0108});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_v !== {1'b0, 32'h0, 32'h0, NOP}) begin
            fails++; $display("FAIL mid_rst_out: got %h want %h", out_v, {1'b0, 32'h0, 32'h0, NOP});
        end
        checks++;
        if (req_v !== {1'b0, RST_PC}) begin
            fails++; $display("FAIL mid_rst_req: got %h want %h", req_v, {1'b0, RST_PC});
        end
        hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_v !== {1'b1, RST_PC}) begin
            fails++; $display("FAIL mid_restart_req: got %h want %h", req_v, {1'b1, RST_PC});
        end
        tick();
        tick();
        checks++;
        if (out_v !== {1'b1, RST_PC, RST_PC + 32'd4, RST_PC + 32'h0000_A000}) begin
            fails++; $display("FAIL mid_restart_out: got %h want %h", out_v, {1'b1, RST_PC, RST_PC + 32'd4, RST_PC + 32'h0000_A000});
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_gnt_low();
        test_reset_midfetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
